// File: rtl/sipo_pkg.sv
// sipo_pkg: shared state encoding and default word width for the SIPO deserializer
package sipo_pkg;
  typedef enum logic {IDLE, RECV} state_t;
  localparam int SIPO_DEFAULT_WIDTH = 8;
endpackage

// File: rtl/sipo.sv
// sipo: LSB-first serial-to-parallel deserializer with a one-word valid/ready output register
module sipo
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  input  logic                  serial_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_err
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_done, w_take, w_load;
  assign w_word = {serial_in, r_shift[DATA_WIDTH-1:1]};
  assign w_done = serial_valid && r_cnt == LAST;
  assign w_take = data_valid && data_ready;
  // a finished word may enter the output register if it is empty or being drained this edge
  assign w_load = w_done && (!data_valid || data_ready);
  assign busy   = r_state == RECV;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (serial_valid) begin
        r_shift <= w_word;
        r_cnt   <= w_done ? '0 : r_cnt + 1'b1;
        r_state <= w_done ? IDLE : RECV;
      end else begin
        r_shift <= '0;
        r_cnt   <= '0;
        r_state <= IDLE;
      end
      frame_err <= r_state == RECV && !serial_valid;
      overrun   <= w_done && data_valid && !data_ready;
      if (w_load) begin
        data_out   <= w_word;
        data_valid <= 1'b1;
      end else if (w_take) begin
        data_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sipo.sv
// tb_sipo: directed vectors for sipo; expected words are queued by stimulus and checked by a handshake monitor
module tb_sipo;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b0;
  logic       serial_valid = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, busy, overrun, frame_err;
  logic [7:0] exp_q[$];
  int vectors = 0, errors = 0;
  int n_valid = 0, n_busy = 0, n_ovr = 0, n_frm = 0;
  logic prev_ovr = 1'b0, prev_frm = 1'b0;

  sipo #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) n_valid++;
      if (busy) n_busy++;
      if (overrun) begin
        n_ovr++;
        check("overrun_single_cycle", {31'd0, prev_ovr}, 32'd0);
      end
      if (frame_err) begin
        n_frm++;
        check("frame_err_single_cycle", {31'd0, prev_frm}, 32'd0);
      end
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", data_out);
        end else begin
          check("word", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        end
      end
    end
    prev_ovr = overrun;
    prev_frm = frame_err;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      serial_valid = 1'b1;
      serial_in    = w[i];
      tick();
    end
  endtask

  task automatic idle(input int n);
    serial_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_counts;
    n_valid = 0;
    n_busy  = 0;
    n_ovr   = 0;
    n_frm   = 0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset_data_out", {24'd0, data_out}, 32'h0);
    check("reset_data_valid", {31'd0, data_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    // single word A5, consumer always ready
    data_ready = 1'b1;
    clear_counts();
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 8);
    idle(3);
    check("a5_valid_cycles", n_valid, 1);
    check("a5_busy_cycles", n_busy, 7);
    check("a5_queue_empty", exp_q.size(), 0);
    // back-to-back words
    clear_counts();
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_bits(8'h3C, 8);
    send_bits(8'hC3, 8);
    idle(3);
    check("b2b_valid_cycles", n_valid, 2);
    check("b2b_queue_empty", exp_q.size(), 0);
    check("b2b_overrun", n_ovr, 0);
    check("b2b_frame_err", n_frm, 0);
    // overrun with a stalled consumer
    data_ready = 1'b0;
    clear_counts();
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 8);
    send_bits(8'hC3, 8);
    idle(3);
    check("ovr_count", n_ovr, 1);
    check("ovr_data_held", {24'd0, data_out}, 32'h3C);
    check("ovr_valid_held", {31'd0, data_valid}, 32'd1);
    data_ready = 1'b1;
    idle(2);
    check("ovr_drained_valid", {31'd0, data_valid}, 32'd0);
    check("ovr_queue_empty", exp_q.size(), 0);
    // aborted partial word
    clear_counts();
    send_bits(8'h07, 3);
    idle(2);
    check("frm_count", n_frm, 1);
    check("frm_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h81);
    send_bits(8'h81, 8);
    idle(3);
    check("frm_next_word", exp_q.size(), 0);
    check("frm_count_after", n_frm, 1);
    // reset mid-word
    clear_counts();
    send_bits(8'hFF, 5);
    serial_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_data_out", {24'd0, data_out}, 32'h0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, data_valid}, 32'd0);
    check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    tick();
    rst = 1'b0;
    idle(2);
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 8);
    idle(3);
    check("rst_no_frame_err", n_frm, 0);
    check("rst_next_word", exp_q.size(), 0);
    // completion on the same edge as a handshake
    data_ready = 1'b0;
    clear_counts();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_bits(8'h11, 8);
    idle(1);
    send_bits(8'h22, 7);
    serial_valid = 1'b1;
    serial_in    = 1'b0;
    data_ready   = 1'b1;
    tick();
    check("same_edge_data", {24'd0, data_out}, 32'h22);
    check("same_edge_valid", {31'd0, data_valid}, 32'd1);
    idle(3);
    check("same_edge_overrun", n_ovr, 0);
    check("same_edge_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/sipo.md
SIPO -- requirements
Module: sipo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per word; legal values are 2 and above.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 serial_in  input  1  serial data bit, LSB first.
REQ-005 serial_valid  input  1  high = serial_in carries a valid bit this cycle.
REQ-006 data_out  output  DATA_WIDTH  assembled parallel word.
REQ-007 data_valid  output  1  data_out holds an unconsumed word.
REQ-008 data_ready  input  1  consumer accepts data_out when high together with data_valid.
REQ-009 busy  output  1  high while a word is partially received.
REQ-010 overrun  output  1  one-cycle pulse: a completed word was dropped.
REQ-011 frame_err  output  1  one-cycle pulse: a partial word was aborted.

Function
REQ-012 Two-state machine: IDLE (bit count 0) and RECV (bit count 1..DATA_WIDTH-1).
REQ-013 Each cycle with serial_valid=1, serial_in is shifted into the shift register at the MSB end, shifting right, and the bit counter increments.
REQ-014 The first sampled bit is data_out[0] and the DATA_WIDTH-th sampled bit is data_out[DATA_WIDTH-1].
REQ-015 IDLE -> RECV on serial_valid=1; RECV -> IDLE on the DATA_WIDTH-th bit or on serial_valid=0.
REQ-016 Bit counter width is $clog2(DATA_WIDTH); it wraps to 0 on word completion.
REQ-017 Word completes on the cycle the DATA_WIDTH-th bit is sampled; the complete word, including that bit, loads into the output register at that edge.
REQ-018 data_valid rises on the edge following the last bit; latency from last bit sampled to data_valid is 1 cycle.
REQ-019 data_valid and data_out hold stable until a cycle with data_valid=1 and data_ready=1; data_valid then clears unless a new word loads on the same edge.
REQ-020 Word completes while the output register is full and data_ready=0: the new word is discarded, data_out is unchanged, and overrun pulses high the following cycle.
REQ-021 Word completes on the same edge as a handshake: the new word loads, data_valid stays 1, and no overrun occurs.
REQ-022 serial_valid=0 in RECV: partial bits are discarded, the counter returns to 0, and frame_err pulses high the following cycle; the output register is unaffected.
REQ-023 Back-to-back words with serial_valid held high need no idle gap; bit 0 of the next word may follow the last bit of the previous word on the next cycle.
REQ-024 busy = (state == RECV), driven from registered state.
REQ-025 overrun and frame_err are registered and never high for more than one consecutive cycle per event.

Reset
REQ-026 rst=1 asynchronously forces: state IDLE, counter 0, shift register 0, data_out 0, data_valid 0, busy 0, overrun 0, frame_err 0.
REQ-027 Reset mid-word discards the partial word without pulsing frame_err; reception restarts cleanly at the first serial_valid after rst deasserts.

Structure
REQ-028 Shared package sipo_pkg holds the state enum typedef (IDLE, RECV) and the default width constant SIPO_DEFAULT_WIDTH = 8.
REQ-029 Single flat module; no sub-module.

Verification
REQ-030 Bits 1,0,1,0,0,1,0,1 with data_ready=1 -> data_out=8'hA5 and data_valid=1 for exactly one cycle, one cycle after the 8th bit; busy high for 7 cycles.
REQ-031 Words 8'h3C then 8'hC3 sent back-to-back with data_ready=1 -> data_valid high two consecutive times, carrying 3C then C3; no overrun or frame_err.
REQ-032 data_ready=0, words 8'h3C then 8'hC3 sent -> data_out holds 3C, overrun pulses once after C3 completes; raising data_ready consumes 3C, then data_valid=0.
REQ-033 3 bits then serial_valid=0 -> frame_err pulses once and busy=0; a following word 8'h81 is received correctly.
REQ-034 rst pulsed after 5 bits of a word -> all outputs 0 and no frame_err; the next full word 8'h5A is received correctly.
REQ-035 data_valid=1 with 8'h11, and data_ready=1 on the same edge word 8'h22 completes -> data_out=8'h22, data_valid remains 1, no overrun.
